// File: rtl/zip_stream_arbiter.sv
// Packet-granular round-robin arbiter feeding one IQ packer from NUM_CH AXI-Stream sources.
// Holds the grant for a whole packet, tags beats with the channel id and flags malformed packets.
module zip_stream_arbiter #(
  parameter int WIDTH         = 32,
  parameter int NUM_CH        = 4,
  parameter int GROUP         = 4,
  parameter int MAX_PKT_BEATS = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CH*WIDTH-1:0]   i_tdata,
  input  logic [NUM_CH-1:0]         i_tlast,
  input  logic [NUM_CH-1:0]         i_tvalid,
  output logic [NUM_CH-1:0]         i_tready,
  output logic [WIDTH-1:0]          o_tdata,
  output logic                      o_tlast,
  output logic                      o_tvalid,
  input  logic                      o_tready,
  output logic [$clog2(NUM_CH)-1:0] o_tuser,
  input  logic [NUM_CH-1:0]         cfg_enable,
  input  logic                      err_clear,
  output logic                      err_misalign,
  output logic                      err_overlen,
  output logic [15:0]               pkt_count
);

  localparam int GW = $clog2(NUM_CH);
  localparam int CW = $clog2(MAX_PKT_BEATS + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state;
  logic [GW-1:0]     grant;
  logic [GW-1:0]     rr_ptr;
  logic [GW-1:0]     next_grant;
  logic [GW-1:0]     idx;
  logic              any_req;
  logic [NUM_CH-1:0] req;
  logic [CW-1:0]     beat_cnt;
  logic [CW:0]       cnt_next;
  logic              hs;
  logic [WIDTH-1:0]  lane [NUM_CH];

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) lane[c] = i_tdata[c*WIDTH +: WIDTH];
  end

  // Search starts one past the last served channel, wrapping at NUM_CH.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    req        = i_tvalid & cfg_enable;
    any_req    = 1'b0;
    next_grant = '0;
    idx        = rr_ptr;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (idx == GW'(NUM_CH - 1)) ? '0 : idx + 1'b1;
      if (!any_req && req[idx]) begin
        any_req    = 1'b1;
        next_grant = idx;
      end
    end
  end

  // Zero-latency pass-through of the granted channel; everything idles to zero otherwise.
  always_comb begin
    o_tdata  = '0;
    o_tlast  = 1'b0;
    o_tvalid = 1'b0;
    o_tuser  = '0;
    i_tready = '0;
    if (state == BUSY) begin
      o_tdata         = lane[grant];
      o_tlast         = i_tlast[grant];
      o_tvalid        = i_tvalid[grant];
      o_tuser         = grant;
      i_tready[grant] = o_tready;
    end
  end

  assign hs       = o_tvalid & o_tready;
  assign cnt_next = {1'b0, beat_cnt} + 1'b1;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      grant        <= '0;
      rr_ptr       <= GW'(NUM_CH - 1);
      beat_cnt     <= '0;
      pkt_count    <= '0;
      err_misalign <= 1'b0;
      err_overlen  <= 1'b0;
    end else begin
      // Later set assignments override the clear, so a set in the same cycle wins.
      if (err_clear) begin
        err_misalign <= 1'b0;
        err_overlen  <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (any_req) begin
            grant <= next_grant;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (hs) begin
            if (o_tlast) begin
              beat_cnt  <= '0;
              pkt_count <= pkt_count + 1'b1;
              rr_ptr    <= grant;
              state     <= IDLE;
              if ((int'(cnt_next) % GROUP) != 0) err_misalign <= 1'b1;
            end else begin
              if (cnt_next == (CW+1)'(MAX_PKT_BEATS)) err_overlen <= 1'b1;
              if (beat_cnt != CW'(MAX_PKT_BEATS)) beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zip_stream_arbiter.sv
// Self-checking bench for zip_stream_arbiter: packet-queue sources, transaction-level
// round-robin reference model, directed scenarios followed by a randomized phase.
module tb_zip_stream_arbiter;

  localparam int WIDTH         = 32;
  localparam int NUM_CH        = 4;
  localparam int GROUP         = 4;
  localparam int MAX_PKT_BEATS = 16;
  localparam int GW            = $clog2(NUM_CH);

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic [NUM_CH*WIDTH-1:0] i_tdata = '0;
  logic [NUM_CH-1:0]       i_tlast = '0;
  logic [NUM_CH-1:0]       i_tvalid = '0;
  logic [NUM_CH-1:0]       i_tready;
  logic [WIDTH-1:0]        o_tdata;
  logic                    o_tlast;
  logic                    o_tvalid;
  logic                    o_tready = 1'b1;
  logic [GW-1:0]           o_tuser;
  logic [NUM_CH-1:0]       cfg_enable = '1;
  logic                    err_clear = 1'b0;
  logic                    err_misalign;
  logic                    err_overlen;
  logic [15:0]             pkt_count;

  zip_stream_arbiter #(
    .WIDTH(WIDTH), .NUM_CH(NUM_CH), .GROUP(GROUP), .MAX_PKT_BEATS(MAX_PKT_BEATS)
  ) dut (
    .clk(clk), .reset(reset),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .o_tuser(o_tuser), .cfg_enable(cfg_enable), .err_clear(err_clear),
    .err_misalign(err_misalign), .err_overlen(err_overlen), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             last;
  } beat_t;

  beat_t             src_q [NUM_CH][$];
  logic [NUM_CH-1:0] gate = '1;
  int                ready_mode = 0;
  bit                rand_mode = 1'b0;
  bit                clear_mode = 1'b0;

  // Reference model: packet-level arbiter state
  bit          m_busy = 1'b0;
  int          m_g = 0;
  int          m_rr = NUM_CH - 1;
  int          m_len = 0;
  logic [15:0] m_pkts = '0;
  bit          m_mis = 1'b0;
  bit          m_ovl = 1'b0;
  int          grant_log[$];
  int          beats_seen = 0;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int c = 0; c < NUM_CH; c++) begin
      if (rand_mode) begin
        gate[c]       = ($urandom_range(0, 3) != 0);
        cfg_enable[c] = ($urandom_range(0, 3) != 0);
      end
      if (src_q[c].size() > 0) begin
        i_tvalid[c]                = gate[c];
        i_tdata[c*WIDTH +: WIDTH]  = src_q[c][0].data;
        i_tlast[c]                 = src_q[c][0].last;
      end else begin
        i_tvalid[c]                = 1'b0;
        i_tdata[c*WIDTH +: WIDTH]  = '0;
        i_tlast[c]                 = 1'b0;
      end
    end
    case (ready_mode)
      0:       o_tready = 1'b1;
      1:       o_tready = ~o_tready;
      default: o_tready = ($urandom_range(0, 3) != 0);
    endcase
    if (rand_mode) err_clear = ($urandom_range(0, 15) == 0);
    else           err_clear = clear_mode && (src_q[1].size() == 1);
  endtask

  task automatic load(input int c, input int n, input bit with_last = 1'b1);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = $urandom;
      b.last = with_last && (i == n - 1);
      src_q[c].push_back(b);
    end
    drive();
  endtask

  // One clock: compare at the falling edge, advance sources and model after the rising edge.
  task automatic cycle();
    logic [NUM_CH-1:0] pop;
    logic [NUM_CH-1:0] req;
    bit          n_busy, n_mis, n_ovl;
    int          n_g, n_rr, n_len, sat, c;
    logic [15:0] n_pkts;
    @(negedge clk);
    check("pkt_count", pkt_count, m_pkts);
    check("err_misalign", err_misalign, m_mis);
    check("err_overlen", err_overlen, m_ovl);
    n_busy = m_busy; n_g = m_g; n_rr = m_rr; n_len = m_len;
    n_pkts = m_pkts; n_mis = m_mis; n_ovl = m_ovl;
    if (err_clear) begin n_mis = 1'b0; n_ovl = 1'b0; end
    if (m_busy) begin
      check("o_tuser", o_tuser, m_g);
      check("o_tvalid", o_tvalid, i_tvalid[m_g]);
      check("o_tdata", o_tdata, i_tdata[m_g*WIDTH +: WIDTH]);
      check("o_tlast", o_tlast, i_tlast[m_g]);
      check("i_tready", i_tready, o_tready ? (1 << m_g) : 0);
      if (i_tvalid[m_g] && o_tready) begin
        beats_seen++;
        sat = (m_len < MAX_PKT_BEATS) ? m_len : MAX_PKT_BEATS;
        if (i_tlast[m_g]) begin
          if (((sat + 1) % GROUP) != 0) n_mis = 1'b1;
          n_len  = 0;
          n_pkts = m_pkts + 16'd1;
          n_rr   = m_g;
          n_busy = 1'b0;
        end else begin
          if (sat + 1 == MAX_PKT_BEATS) n_ovl = 1'b1;
          n_len = m_len + 1;
        end
      end
    end else begin
      check("idle_o_tvalid", o_tvalid, 0);
      check("idle_i_tready", i_tready, 0);
      check("idle_o_tdata", o_tdata, 0);
      check("idle_o_tlast", o_tlast, 0);
      check("idle_o_tuser", o_tuser, 0);
      req = i_tvalid & cfg_enable;
      for (int k = 1; k <= NUM_CH; k++) begin
        c = (m_rr + k) % NUM_CH;
        if (!n_busy && req[c]) begin
          n_busy = 1'b1;
          n_g    = c;
          if (!reset) grant_log.push_back(c);
        end
      end
    end
    if (reset) begin
      n_busy = 1'b0; n_g = 0; n_rr = NUM_CH - 1; n_len = 0;
      n_pkts = '0; n_mis = 1'b0; n_ovl = 1'b0;
    end
    pop = i_tvalid & i_tready;
    @(posedge clk);
    #1;
    for (int k = 0; k < NUM_CH; k++) if (pop[k]) void'(src_q[k].pop_front());
    m_busy = n_busy; m_g = n_g; m_rr = n_rr; m_len = n_len;
    m_pkts = n_pkts; m_mis = n_mis; m_ovl = n_ovl;
    drive();
  endtask

  task automatic run_beats(input int n);
    int target;
    int budget;
    target = beats_seen + n;
    budget = 0;
    while (beats_seen < target && budget < 500) begin
      cycle();
      budget++;
    end
    check("run_beats_reached", beats_seen, target);
  endtask

  task automatic drain();
    int budget;
    int pending;
    budget = 0;
    pending = 1;
    while (pending != 0 && budget < 3000) begin
      cycle();
      budget++;
      pending = m_busy ? 1 : 0;
      for (int c = 0; c < NUM_CH; c++) pending += src_q[c].size();
    end
    check("drain_done", pending, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    grant_log.delete();
  endtask

  int exp_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int lens[8]      = '{4, 8, 12, 16, 5, 6, 18, 20};

  initial begin
    drive();

    // Reset state
    do_reset();
    #2;
    check("rst_o_tvalid", o_tvalid, 0);
    check("rst_i_tready", i_tready, 0);
    check("rst_o_tuser", o_tuser, 0);
    check("rst_o_tdata", o_tdata, 0);
    check("rst_o_tlast", o_tlast, 0);
    check("rst_pkt_count", pkt_count, 0);
    check("rst_errs", {err_misalign, err_overlen}, 0);

    // ch0 and ch2 contend: ch0 first, then ch2
    load(0, 8);
    load(2, 8);
    drain();
    check("t1_grants", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      check("t1_first", grant_log[0], 0);
      check("t1_second", grant_log[1], 2);
    end
    check("t1_pkt_count", pkt_count, 2);

    // All channels continuously valid: strict rotation
    do_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      load(c, 4);
      load(c, 4);
    end
    drain();
    check("t2_grants", grant_log.size(), 8);
    for (int i = 0; i < grant_log.size() && i < 8; i++) check("t2_order", grant_log[i], exp_order[i]);
    check("t2_pkt_count", pkt_count, 8);

    // Backpressure toggling on ch1 while ch3 waits
    do_reset();
    ready_mode = 1;
    load(1, 8);
    load(3, 4);
    while (src_q[1].size() > 0 && beats_seen < 100000) begin
      cycle();
      #2;
      check("t3_ch3_held", i_tready[3], 0);
    end
    ready_mode = 0;
    drain();
    check("t3_grants", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      check("t3_first", grant_log[0], 1);
      check("t3_second", grant_log[1], 3);
    end

    // Misaligned packet, clear, then set and clear together
    do_reset();
    load(1, 6);
    drain();
    check("t4_misalign_set", err_misalign, 1);
    err_clear = 1'b1;
    cycle();
    check("t4_misalign_cleared", err_misalign, 0);
    clear_mode = 1'b1;
    load(1, 6);
    drain();
    clear_mode = 1'b0;
    check("t4_set_wins", err_misalign, 1);

    // Over-length packet: flag on the 16th beat, beats keep flowing
    do_reset();
    load(0, 20, 1'b0);
    run_beats(15);
    check("t5_overlen_before", err_overlen, 0);
    run_beats(1);
    check("t5_overlen_at16", err_overlen, 1);
    run_beats(4);
    check("t5_beats_passed", src_q[0].size(), 0);
    check("t5_beat_cnt_hold", dut.beat_cnt, MAX_PKT_BEATS);
    check("t5_no_misalign", err_misalign, 0);

    // Reset in the middle of a ch2 packet
    do_reset();
    load(2, 8);
    run_beats(2);
    reset = 1'b1;
    load(1, 4);
    cycle();
    reset = 1'b0;
    grant_log.delete();
    #2;
    check("t6_o_tvalid", o_tvalid, 0);
    check("t6_i_tready", i_tready, 0);
    check("t6_o_tdata", o_tdata, 0);
    check("t6_o_tuser", o_tuser, 0);
    check("t6_pkt_count", pkt_count, 0);
    drain();
    check("t6_grants", grant_log.size(), 2);
    if (grant_log.size() == 2) check("t6_first", grant_log[0], 1);
    check("t6_pkt_after", pkt_count, 2);
    check("t6_remainder_misaligned", err_misalign, 1);

    // Randomized traffic with gating, enables, backpressure and clears
    do_reset();
    rand_mode  = 1'b1;
    ready_mode = 2;
    for (int i = 0; i < 2000; i++) begin
      if (i % 6 == 0) begin
        int c;
        c = $urandom_range(0, NUM_CH - 1);
        if (src_q[c].size() < 40) load(c, lens[$urandom_range(0, 7)]);
      end
      cycle();
    end
    rand_mode  = 1'b0;
    ready_mode = 0;
    gate       = '1;
    cfg_enable = '1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
